// File: rtl/pipe_pkg.sv
// pipe_pkg: shared scoreboard types and helpers for the hazard controller
package pipe_pkg;
   localparam int RA_W = 5;
   localparam int FWD_REGFILE = 0;
   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
      logic            reg_write;
      logic            mem_read;
   } sb_entry_t;
   function automatic int fw_w(input int depth);
      return $clog2(depth);
   endfunction
   function automatic logic is_writer(input sb_entry_t e);
      return e.valid && e.reg_write && e.rd != '0;
   endfunction
   function automatic logic reads_dest(input sb_entry_t e, input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                                       input logic uses_rs, input logic uses_rt);
      return is_writer(e) && ((uses_rs && e.rd == rs) || (uses_rt && e.rd == rt));
   endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// fwd_select: nearest-producer priority encoder for one EX operand
module fwd_select
   import pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int LOAD_READY = 2,
   parameter int FW_W = fw_w(DEPTH)
) (
   input  sb_entry_t             sb [1:DEPTH],
   input  logic [pipe_pkg::RA_W-1:0] r,
   input  logic                  used,
   output logic [FW_W-1:0]       sel
);
   always_comb begin
      sel = FW_W'(FWD_REGFILE);
      // scan oldest to youngest so the nearest producer overwrites
      for (int k = DEPTH; k >= 2; k--)
         sel = (used && r != '0 && is_writer(sb[k]) && sb[k].rd == r && (!sb[k].mem_read || k > LOAD_READY))
               ? FW_W'(k - 1) : sel;
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based stall, flush and EX forwarding control
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int RA_W = pipe_pkg::RA_W,
   parameter int LOAD_READY = 2,
   parameter int BRANCH_IN_ID = 1,
   parameter int FW_W = fw_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_is_branch,
   input  logic             branch_taken,
   input  logic             jump,
   output logic             id_en,
   output logic             stall,
   output logic             if_flush,
   output logic [FW_W-1:0]  fwd_a,
   output logic [FW_W-1:0]  fwd_b,
   output logic [DEPTH-1:0] stage_valid
);
   sb_entry_t sb [1:DEPTH];
   logic [RA_W-1:0] ex_rs, ex_rt;
   logic ex_uses_rs, ex_uses_rt;
   logic load_use, br_hz;
   always_comb begin
      load_use = 1'b0;
      br_hz = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
         load_use |= id_valid && k < LOAD_READY && sb[k].mem_read
                     && reads_dest(sb[k], id_rs, id_rt, id_uses_rs, id_uses_rt);
         // ID compares need the value one stage earlier than EX does
         br_hz |= BRANCH_IN_ID != 0 && id_is_branch && (k < LOAD_READY || (sb[k].mem_read && k <= LOAD_READY))
                  && reads_dest(sb[k], id_rs, id_rt, id_uses_rs, id_uses_rt);
      end
   end
   assign stall = load_use | br_hz;
   assign id_en = !stall && !hold;
   assign if_flush = (branch_taken || jump) && !stall && !hold;
   always_comb
      for (int k = 1; k <= DEPTH; k++) stage_valid[k-1] = sb[k].valid;
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
         ex_rs <= '0;
         ex_rt <= '0;
         ex_uses_rs <= 1'b0;
         ex_uses_rt <= 1'b0;
      end else if (!hold) begin
         sb[1] <= '{valid: id_valid && !stall, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
         for (int k = 2; k <= DEPTH; k++) sb[k] <= sb[k-1];
         ex_rs <= id_rs;
         ex_rt <= id_rt;
         ex_uses_rs <= id_uses_rs;
         ex_uses_rt <= id_uses_rt;
      end
   end
   fwd_select #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .FW_W(FW_W)) u_fwd_a (
      .sb(sb), .r(ex_rs), .used(ex_uses_rs), .sel(fwd_a)
   );
   fwd_select #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .FW_W(FW_W)) u_fwd_b (
      .sb(sb), .r(ex_rt), .used(ex_uses_rt), .sel(fwd_b)
   );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, flush, forwarding and occupancy
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic reset, hold, id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_is_branch, branch_taken, jump;
   logic [4:0] id_rs, id_rt, id_rd;
   logic id_en, stall, if_flush;
   logic [1:0] fwd_a, fwd_b;
   logic [2:0] stage_valid;
   int n_cmp = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_is_branch(id_is_branch), .branch_taken(branch_taken), .jump(jump),
      .id_en(id_en), .stall(stall), .if_flush(if_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stage_valid(stage_valid)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic br, input logic bt);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_is_branch = br; branch_taken = bt; jump = 1'b0;
      #1;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) tick();
   endtask
   initial begin
      reset = 1'b1;
      hold = 1'b0;
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      tick();
      tick();
      chk("rst_stage_valid", stage_valid, 0);
      chk("rst_id_en", id_en, 1);
      chk("rst_stall", stall, 0);
      chk("rst_flush", if_flush, 0);
      chk("rst_fwd_a", fwd_a, 0);
      chk("rst_fwd_b", fwd_b, 0);
      reset = 1'b0;
      tick();
      chk("fill1", stage_valid, 3'b001);
      tick();
      tick();
      chk("fill3", stage_valid, 3'b111);
      idle(3);
      chk("drain", stage_valid, 0);
      // add $3,$1,$2 ; sub $4,$3,$5
      drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      tick();
      drive(1, 3, 5, 1, 1, 4, 1, 0, 0, 0);
      chk("alu_no_stall", stall, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("fwd_mem_a", fwd_a, 1);
      chk("fwd_mem_b", fwd_b, 0);
      idle(3);
      // add $3 ; independent ; sub $4,$3,$5
      drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      tick();
      drive(1, 8, 9, 1, 1, 10, 1, 0, 0, 0);
      tick();
      drive(1, 3, 5, 1, 1, 4, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("fwd_wb_a", fwd_a, 2);
      idle(3);
      // lw $3 ; add $4,$3,$3
      drive(1, 1, 0, 1, 0, 3, 1, 1, 0, 0);
      tick();
      drive(1, 3, 3, 1, 1, 4, 1, 0, 0, 0);
      chk("lu_stall", stall, 1);
      chk("lu_id_en", id_en, 0);
      tick();
      chk("lu_stall_end", stall, 0);
      chk("lu_id_en_end", id_en, 1);
      chk("lu_bubble", stage_valid, 3'b010);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_fwd_a", fwd_a, 2);
      chk("lu_fwd_b", fwd_b, 2);
      chk("lu_occupancy", stage_valid, 3'b101);
      idle(3);
      // lw $3 ; beq $3,$0 taken
      drive(1, 1, 0, 1, 0, 3, 1, 1, 0, 0);
      tick();
      drive(1, 3, 0, 1, 1, 0, 0, 0, 1, 1);
      chk("lb_stall1", stall, 1);
      chk("lb_flush1", if_flush, 0);
      tick();
      chk("lb_stall2", stall, 1);
      chk("lb_flush2", if_flush, 0);
      chk("lb_id_en2", id_en, 0);
      tick();
      chk("lb_stall3", stall, 0);
      chk("lb_flush3", if_flush, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lb_flush_once", if_flush, 0);
      idle(3);
      // hold with a taken branch in ID
      drive(1, 0, 0, 0, 0, 12, 1, 0, 0, 0);
      tick();
      drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 1);
      hold = 1'b1;
      #1;
      chk("hold_flush", if_flush, 0);
      chk("hold_id_en", id_en, 0);
      chk("hold_stall", stall, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hold_frozen", stage_valid, 3'b001);
         chk("hold_no_flush", if_flush, 0);
      end
      hold = 1'b0;
      #1;
      chk("unhold_flush", if_flush, 1);
      chk("unhold_id_en", id_en, 1);
      tick();
      chk("unhold_advance", stage_valid, 3'b011);
      idle(3);
      // addi $0,$0,5 ; reader of $0
      drive(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      tick();
      drive(1, 0, 0, 1, 1, 9, 1, 0, 1, 0);
      chk("r0_no_stall", stall, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("r0_fwd_a", fwd_a, 0);
      idle(3);
      // two writers of $7, then a reader using only rt
      drive(1, 1, 1, 1, 1, 7, 1, 0, 0, 0);
      tick();
      drive(1, 2, 2, 1, 1, 7, 1, 0, 0, 0);
      tick();
      drive(1, 7, 7, 0, 1, 11, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("nearest_fwd_b", fwd_b, 1);
      chk("unused_fwd_a", fwd_a, 0);
      idle(3);
      // ALU writer then branch reading it: one stall
      drive(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
      tick();
      drive(1, 5, 0, 1, 1, 0, 0, 0, 1, 0);
      chk("ab_stall", stall, 1);
      tick();
      chk("ab_stall_end", stall, 0);
      tick();
      // reset asserted during hold clears state
      drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
      tick();
      hold = 1'b1;
      reset = 1'b1;
      tick();
      chk("rst_in_hold", stage_valid, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
